// File: rtl/rst_sequencer.sv
`timescale 1ns/1ps
// Multi-channel reset sequencer: async assert, synchronised and staggered release, per-channel SW pulses.
// Latency: rst_n_out[k] rises STAGES+MIN_ASSERT+1+k*RELEASE_GAP edges after async_rst_n deasserts; no flow control.
module rst_sequencer #(
    parameter int STAGES      = 2,
    parameter int NUM_CH      = 4,
    parameter int MIN_ASSERT  = 8,
    parameter int RELEASE_GAP = 4,
    parameter int SW_PULSE    = 4
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic [NUM_CH-1:0] sw_rst_req,
    output logic [NUM_CH-1:0] rst_n_out,
    output logic              seq_busy,
    output logic              rst_done
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("rst_sequencer: STAGES must be >= 2");
        end
        if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
            $error("rst_sequencer: NUM_CH must be in 1..16");
        end
        if (MIN_ASSERT < 1 || RELEASE_GAP < 1 || SW_PULSE < 1) begin : g_bad_counts
            $error("rst_sequencer: MIN_ASSERT, RELEASE_GAP and SW_PULSE must be >= 1");
        end
    endgenerate

    localparam int MA_W  = $clog2(MIN_ASSERT + 1);
    localparam int GAP_W = $clog2(RELEASE_GAP + 1);
    localparam int SW_W  = $clog2(SW_PULSE + 1);
    localparam int IDX_W = $clog2(NUM_CH + 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        STRETCH = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q;
    logic [STAGES-1:0] sync_q;
    logic [MA_W-1:0]   cnt_q;
    logic [GAP_W-1:0]  gap_q;
    logic [IDX_W-1:0]  idx_q;
    logic [NUM_CH-1:0] rel_q;
    logic [NUM_CH-1:0] out_q;
    logic              busy_q;
    logic              done_q;
    logic [SW_W-1:0]   sw_cnt_q [NUM_CH];

    logic [SW_W-1:0]   sw_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] raise_d;
    logic              last_raise_d;
    logic [NUM_CH-1:0] out_d;

    // One-hot of the channel the sequence releases on this edge; idx_q is the last released channel.
    always_comb begin
        raise_d      = '0;
        last_raise_d = 1'b0;
        case (state_q)
            STRETCH: begin
                if (cnt_q == MA_W'(MIN_ASSERT - 1)) begin
                    raise_d[0]   = 1'b1;
                    last_raise_d = (NUM_CH == 1);
                end
            end
            RELEASE: begin
                if (gap_q == GAP_W'(RELEASE_GAP - 1)) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        raise_d[i] = (IDX_W'(i) == idx_q + IDX_W'(1));
                    end
                    last_raise_d = (idx_q == IDX_W'(NUM_CH - 2));
                end
            end
            default: ;
        endcase
    end

    // SW pulses only start on channels already released; a new request reloads the counter.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sw_cnt_d[i] = '0;
            if (sw_rst_req[i] && rel_q[i]) begin
                sw_cnt_d[i] = SW_W'(SW_PULSE);
            end else if (sw_cnt_q[i] != '0) begin
                sw_cnt_d[i] = sw_cnt_q[i] - SW_W'(1);
            end
            out_d[i] = (rel_q[i] | raise_d[i]) & (sw_cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            sync_q  <= '0;
            state_q <= HOLD;
            cnt_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            out_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                sw_cnt_q[i] <= '0;
            end
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b1};
            rel_q  <= rel_q | raise_d;
            out_q  <= out_d;
            for (int i = 0; i < NUM_CH; i++) begin
                sw_cnt_q[i] <= sw_cnt_d[i];
            end
            case (state_q)
                HOLD: begin
                    if (sync_q[STAGES-1]) begin
                        state_q <= STRETCH;
                        cnt_q   <= '0;
                    end
                end
                STRETCH: begin
                    if (cnt_q == MA_W'(MIN_ASSERT - 1)) begin
                        idx_q <= '0;
                        gap_q <= '0;
                        if (last_raise_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RELEASE;
                        end
                    end else begin
                        cnt_q <= cnt_q + MA_W'(1);
                    end
                end
                RELEASE: begin
                    if (gap_q == GAP_W'(RELEASE_GAP - 1)) begin
                        idx_q <= idx_q + IDX_W'(1);
                        gap_q <= '0;
                        if (last_raise_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                DONE: ;
                default: state_q <= HOLD;
            endcase
        end
    end

    assign rst_n_out = out_q;
    assign seq_busy  = busy_q;
    assign rst_done  = done_q;

endmodule
